// File: rtl/soc_mem_responder_if.sv
// Bus bundle between the RV32 core/host side and the memory responder:
// program load stream, instruction fetch, data bus, output FIFO and status.
interface soc_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic [31:0]      load_data;
  logic             load_last;
  logic             load_ready;
  logic             core_nreset;
  logic [WIDTH-1:0] programaddress;
  logic [31:0]      programdata;
  logic [WIDTH-1:0] ramaddress;
  logic             writeram;
  logic [WIDTH-1:0] writeramdata;
  logic [WIDTH-1:0] readramdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             done;

  // Responder side
  modport slave (
    input  load_valid, load_data, load_last,
    input  programaddress, ramaddress, writeram, writeramdata, out_ready,
    output load_ready, core_nreset, programdata, readramdata,
    output out_valid, out_data, done
  );

  // Host/core side
  modport master (
    output load_valid, load_data, load_last,
    output programaddress, ramaddress, writeram, writeramdata, out_ready,
    input  load_ready, core_nreset, programdata, readramdata,
    input  out_valid, out_data, done
  );
endinterface

// File: rtl/soc_mem_responder.sv
// Memory-side responder for the 2-stage RV32 core: instruction memory loaded
// by the host at boot, data memory, memory-mapped output FIFO and done flag.
module soc_mem_responder #(
  parameter int                  WIDTH       = 32,
  parameter int unsigned         IMEM_WORDS  = 1024,
  parameter int unsigned         DMEM_WORDS  = 4096,
  parameter int unsigned         FIFO_DEPTH  = 8,
  parameter logic [WIDTH-1:0]    OUT_ADDR    = 32'h0001_0000,
  parameter logic [WIDTH-1:0]    STATUS_ADDR = 32'h0001_0004,
  parameter logic [WIDTH-1:0]    DONE_ADDR   = 32'h0001_0008
) (
  input logic                clk,
  input logic                nrst,
  soc_mem_responder_if.slave bus
);

  localparam int unsigned IA = $clog2(IMEM_WORDS);
  localparam int unsigned DA = $clog2(DMEM_WORDS);
  localparam int unsigned FA = $clog2(FIFO_DEPTH);
  localparam logic [FA:0] FULL_CNT = (FA + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t           state;
  logic [IA-1:0]    load_ptr;
  logic             core_nreset_q;
  logic             done_q;

  logic [31:0]      imem [IMEM_WORDS];
  logic [WIDTH-1:0] dmem [DMEM_WORDS];
  logic [WIDTH-1:0] fifo [FIFO_DEPTH];

  logic [FA-1:0]    wr_ptr;
  logic [FA-1:0]    rd_ptr;
  logic [FA:0]      count;
  logic             overflow;

  logic             load_fire;
  logic             wr_en;
  logic             in_imem;
  logic             in_dmem;
  logic             is_out;
  logic             is_status;
  logic             is_done;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic [WIDTH-1:0] status_word;
  logic             unused_addr_bits;

  assign load_fire = (state == LOAD) & bus.load_valid;
  assign wr_en     = bus.writeram & core_nreset_q;
  assign in_imem   = (bus.programaddress >> (IA + 2)) == '0;
  assign in_dmem   = (bus.ramaddress >> (DA + 2)) == '0;
  assign is_out    = bus.ramaddress == OUT_ADDR;
  assign is_status = bus.ramaddress == STATUS_ADDR;
  assign is_done   = bus.ramaddress == DONE_ADDR;

  assign full      = count == FULL_CNT;
  assign pop       = (count != '0) & bus.out_ready;
  assign push_req  = wr_en & is_out;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok   = push_req & (~full | pop);

  assign unused_addr_bits = ^{bus.programaddress[1:0], bus.ramaddress[1:0]};

  assign bus.load_ready  = state == LOAD;
  assign bus.core_nreset = core_nreset_q;
  assign bus.done        = done_q;
  assign bus.out_valid   = count != '0;
  assign bus.out_data    = fifo[rd_ptr];

  // Boot/run sequencing: load program, release core, latch end of program
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= LOAD;
      load_ptr      <= '0;
      core_nreset_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          core_nreset_q <= 1'b0;
          if (load_fire) begin
            load_ptr <= load_ptr + 1'b1;
            if (bus.load_last || (&load_ptr)) state <= RUN;
          end
        end
        RUN: begin
          core_nreset_q <= 1'b1;
          if (wr_en && is_done) begin
            state  <= HALT;
            done_q <= 1'b1;
          end
        end
        HALT:    core_nreset_q <= 1'b1;
        default: state <= LOAD;
      endcase
    end
  end

  // Program words from the host land in instruction memory
  always_ff @(posedge clk) begin
    if (load_fire) imem[load_ptr] <= bus.load_data;
  end

  // Core stores into data memory once it is out of reset
  always_ff @(posedge clk) begin
    if (wr_en && in_dmem) dmem[bus.ramaddress[DA+1:2]] <= bus.writeramdata;
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= bus.writeramdata;
  end

  // Output FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Zero-latency instruction fetch, NOP outside instruction memory
  always_comb begin
    bus.programdata = NOP;
    if (in_imem) bus.programdata = imem[bus.programaddress[IA+1:2]];
  end

  // Data read mux: data memory, FIFO status, else zero
  always_comb begin
    status_word         = '0;
    status_word[FA+2:0] = {overflow, full, count};
    bus.readramdata     = '0;
    if (in_dmem)        bus.readramdata = dmem[bus.ramaddress[DA+1:2]];
    else if (is_status) bus.readramdata = status_word;
  end

endmodule

// File: tb/tb_soc_mem_responder.sv
// Bench for soc_mem_responder: boot vector table, directed FIFO/done/reset
// sequences and a randomized phase against a queue-based reference model.
module tb_soc_mem_responder;

  localparam logic [31:0] OUT_ADDR    = 32'h0001_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h0001_0004;
  localparam logic [31:0] DONE_ADDR   = 32'h0001_0008;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  soc_mem_responder_if #(.WIDTH(32)) bus ();

  soc_mem_responder #(
    .WIDTH(32), .IMEM_WORDS(1024), .DMEM_WORDS(4096), .FIFO_DEPTH(8),
    .OUT_ADDR(OUT_ADDR), .STATUS_ADDR(STATUS_ADDR), .DONE_ADDR(DONE_ADDR)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic [31:0] pa;
    logic        er;
    logic        ecn;
    logic        cpd;
    logic [31:0] epd;
  } bvec_t;

  bvec_t bt [8];

  // Reference model state
  logic [31:0] mq[$];
  logic        movf;
  logic [31:0] mdm[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    bus.writeram     = 1'b1;
    bus.ramaddress   = OUT_ADDR;
    bus.writeramdata = d;
    tick();
    bus.writeram     = 1'b0;
  endtask

  // Reset, then boot the 3-word program while the core tries a store
  task automatic reboot();
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_8113;
    prog[2] = 32'h0000_0013;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    bus.writeram     = 1'b1;
    bus.ramaddress   = 32'h0000_0020;
    bus.writeramdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_last  = (i == 2);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.writeram   = 1'b0;
    tick();
    #1;
    chk("reboot_core_nreset", {31'd0, bus.core_nreset}, 32'd1);
  endtask

  initial begin
    logic [31:0] addr, data, exp_st;
    logic        wr, rdy, pop;
    int          r, idx;

    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    bus.programaddress = '0; bus.ramaddress = '0; bus.writeram = 1'b0;
    bus.writeramdata = '0; bus.out_ready = 1'b0;

    bt[0] = '{1'b1, 32'h0050_0093, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    bt[1] = '{1'b1, 32'h0010_8113, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0050_0093};
    bt[2] = '{1'b1, 32'h0000_0013, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h0010_8113};
    bt[3] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0000_0013};
    bt[4] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 32'h0010_8113};
    bt[5] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 32'h0000_0013};
    bt[6] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0050_0093};
    bt[7] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 1'b1, 32'h0050_0093};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("rst_core_nreset", {31'd0, bus.core_nreset}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    nrst = 1'b1;
    tick();

    // Boot table
    for (int i = 0; i < 8; i++) begin
      bus.load_valid     = bt[i].lv;
      bus.load_data      = bt[i].ld;
      bus.load_last      = bt[i].ll;
      bus.programaddress = bt[i].pa;
      #1;
      chk($sformatf("boot%0d_load_ready", i), {31'd0, bus.load_ready}, {31'd0, bt[i].er});
      chk($sformatf("boot%0d_core_nreset", i), {31'd0, bus.core_nreset}, {31'd0, bt[i].ecn});
      if (bt[i].cpd) chk($sformatf("boot%0d_programdata", i), bus.programdata, bt[i].epd);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;

    // DMEM store/read, unmapped and empty status reads
    bus.writeram = 1'b1; bus.ramaddress = 32'h10; bus.writeramdata = 32'hDEAD_BEEF;
    tick();
    bus.ramaddress = 32'h20; bus.writeramdata = 32'h1111_1111;
    tick();
    bus.writeram = 1'b0; bus.ramaddress = 32'h13;
    #1 chk("dmem_read_0x13", bus.readramdata, 32'hDEAD_BEEF);
    bus.ramaddress = 32'h0002_0000;
    #1 chk("unmapped_read", bus.readramdata, 32'h0);
    bus.ramaddress = 32'h0000_4000;
    #1 chk("past_dmem_read", bus.readramdata, 32'h0);
    bus.ramaddress = STATUS_ADDR;
    #1 chk("status_empty", bus.readramdata, 32'h0);

    // FIFO fill and overflow, then drain in order
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 9; v++) push(v);
    bus.ramaddress = STATUS_ADDR;
    #1 chk("status_full_ovf", bus.readramdata, 32'h38);
    bus.out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      #1;
      chk($sformatf("drain%0d_valid", v), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("drain%0d_data", v), bus.out_data, v);
      tick();
    end
    #1 chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Reboot: dmem retained, store during LOAD dropped
    reboot();
    bus.ramaddress = 32'h20;
    #1 chk("load_store_dropped", bus.readramdata, 32'h1111_1111);

    // Full FIFO with simultaneous push and pop
    for (int v = 0; v < 8; v++) push(32'h10 + v);
    bus.writeram = 1'b1; bus.ramaddress = OUT_ADDR; bus.writeramdata = 32'hAA;
    bus.out_ready = 1'b1;
    #1 chk("fullpp_head", bus.out_data, 32'h10);
    tick();
    bus.writeram = 1'b0; bus.out_ready = 1'b0; bus.ramaddress = STATUS_ADDR;
    #1 chk("fullpp_status", bus.readramdata, 32'h18);
    bus.out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      #1 chk($sformatf("fullpp_out%0d", v), bus.out_data, (v == 7) ? 32'hAA : 32'h11 + v);
      tick();
    end
    #1 chk("fullpp_empty", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Done flag, pushes still accepted afterwards
    bus.writeram = 1'b1; bus.ramaddress = DONE_ADDR;
    #1 chk("done_before", {31'd0, bus.done}, 32'd0);
    tick();
    bus.writeram = 1'b0;
    #1 chk("done_after", {31'd0, bus.done}, 32'd1);
    chk("halt_load_ready", {31'd0, bus.load_ready}, 32'd0);
    push(32'h55);
    #1 chk("halt_push_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("halt_push_data", bus.out_data, 32'h55);

    // Randomized traffic against the reference model
    mq.delete();
    mq.push_back(32'h55);
    movf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r    = $urandom_range(0, 9);
      wr   = $urandom_range(0, 1);
      rdy  = ($urandom_range(0, 2) == 0);
      data = $urandom;
      if (r < 4)      addr = OUT_ADDR;
      else if (r < 6) addr = STATUS_ADDR;
      else            addr = 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      bus.writeram = wr; bus.ramaddress = addr; bus.writeramdata = data;
      bus.out_ready = rdy;
      #1;
      chk("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) chk("rnd_out_data", bus.out_data, mq[0]);
      if (addr == STATUS_ADDR) begin
        exp_st = {26'd0, movf, mq.size() == 8, 4'(mq.size())};
        chk("rnd_status", bus.readramdata, exp_st);
      end else if (addr == OUT_ADDR) begin
        chk("rnd_out_addr_read", bus.readramdata, 32'h0);
      end else begin
        idx = int'(addr >> 2);
        if (mdm.exists(idx)) chk("rnd_dmem", bus.readramdata, mdm[idx]);
      end
      tick();
      pop = (mq.size() != 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (wr && addr == OUT_ADDR) begin
        if (mq.size() < 8) mq.push_back(data);
        else               movf = 1'b1;
      end
      if (wr && addr != OUT_ADDR && addr != STATUS_ADDR) mdm[int'(addr >> 2)] = data;
    end
    bus.writeram = 1'b0;

    // Reset while the core runs with 5 words queued
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.out_ready = 1'b0;
    for (int v = 0; v < 5; v++) push(32'h70 + v);
    bus.ramaddress = STATUS_ADDR;
    #1 chk("pre_rst_count", bus.readramdata & 32'h1F, 32'h5);
    chk("pre_rst_done", {31'd0, bus.done}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("midrst_core_nreset", {31'd0, bus.core_nreset}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    nrst = 1'b1;
    #1;
    chk("postrst_load_ready", {31'd0, bus.load_ready}, 32'd1);
    chk("postrst_done", {31'd0, bus.done}, 32'd0);
    chk("postrst_status", bus.readramdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
